// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default widths for the frame-buffer sram arbiter
package sram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_ADDR_WIDTH = 17;
    localparam int DEF_RAM_SIZE   = 76800;
    localparam int DEF_MAX_WAIT   = 8;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_A,
        SRC_B,
        SRC_FILL
    } src_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester, fill-control and sram-side signals of the arbiter
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  fill_start;
    logic [DATA_WIDTH-1:0] fill_value;
    logic                  fill_busy;
    logic                  fill_done;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
               fill_start, fill_value, mem_rdata,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
               fill_busy, fill_done, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
               fill_start, fill_value, mem_rdata,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
               fill_busy, fill_done, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram_fill_engine.sv
// rtl/sram_fill_engine.sv - whole-buffer clear: owns the IDLE/FILL state, pointer and colour
module sram_fill_engine
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_SIZE   = DEF_RAM_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  step,
    output state_t                state,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic [DATA_WIDTH-1:0] color,
    output logic                  busy,
    output logic                  done
);

    // step is only asserted by the arbiter while in FILL; start is ignored once busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            color <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        busy  <= 1'b1;
                        ptr   <= '0;
                        color <= value;
                    end
                end
                FILL: begin
                    if (step) begin
                        if (ptr == ADDR_WIDTH'(RAM_SIZE - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares the single-port frame-buffer sram between scan-out, draw logic and fill
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RAM_SIZE   = DEF_RAM_SIZE,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input logic           clk,
    input logic           reset_n,
    sram_arbiter_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t                state;
    src_t                  src;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  starve;
    logic                  fill_step;
    logic [ADDR_WIDTH-1:0] fill_ptr;
    logic [DATA_WIDTH-1:0] fill_color;
    logic                  fill_busy;
    logic                  fill_done;
    logic                  a_rvalid_q, b_rvalid_q;
    logic                  a_oor_q, b_oor_q;
    logic [DATA_WIDTH-1:0] a_hold, b_hold;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return addr < ADDR_WIDTH'(RAM_SIZE);
    endfunction

    assign starve = (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        src = SRC_NONE;
        if (!reset_n) begin
            src = SRC_NONE;
        end else if (state == FILL) begin
            src = bus.a_req ? SRC_A : SRC_FILL;
        end else if (bus.b_req && (starve || !bus.a_req)) begin
            src = SRC_B;
        end else if (bus.a_req) begin
            src = SRC_A;
        end
    end

    assign fill_step = (src == SRC_FILL);
    assign bus.a_gnt = (src == SRC_A);
    assign bus.b_gnt = (src == SRC_B);

    // Out-of-range requests are granted but never reach the sram
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (src)
            SRC_A: begin
                bus.mem_en   = in_range(bus.a_addr);
                bus.mem_addr = bus.a_addr;
            end
            SRC_B: begin
                bus.mem_en    = in_range(bus.b_addr);
                bus.mem_we    = bus.b_we && in_range(bus.b_addr);
                bus.mem_addr  = bus.b_addr;
                bus.mem_wdata = bus.b_wdata;
            end
            SRC_FILL: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = fill_ptr;
                bus.mem_wdata = fill_color;
            end
            default: ;
        endcase
    end

    // The sram registers its output, so rdata is taken straight from mem_rdata in the valid cycle
    assign a_rdata = a_rvalid_q ? (a_oor_q ? '0 : bus.mem_rdata) : a_hold;
    assign b_rdata = b_rvalid_q ? (b_oor_q ? '0 : bus.mem_rdata) : b_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_oor_q    <= 1'b0;
            b_oor_q    <= 1'b0;
            a_hold     <= '0;
            b_hold     <= '0;
            wait_cnt   <= '0;
        end else begin
            a_rvalid_q <= bus.a_gnt;
            a_oor_q    <= !in_range(bus.a_addr);
            b_rvalid_q <= bus.b_gnt && !bus.b_we;
            b_oor_q    <= !in_range(bus.b_addr);
            if (a_rvalid_q) a_hold <= a_rdata;
            if (b_rvalid_q) b_hold <= b_rdata;
            if (state == IDLE) begin
                if (!bus.b_req || bus.b_gnt) begin
                    wait_cnt <= '0;
                end else if (!starve) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.a_rvalid  = a_rvalid_q;
    assign bus.b_rvalid  = b_rvalid_q;
    assign bus.a_rdata   = a_rdata;
    assign bus.b_rdata   = b_rdata;
    assign bus.fill_busy = fill_busy;
    assign bus.fill_done = fill_done;

    sram_fill_engine #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .RAM_SIZE  (RAM_SIZE)
    ) u_fill (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (bus.fill_start),
        .value  (bus.fill_value),
        .step   (fill_step),
        .state  (state),
        .ptr    (fill_ptr),
        .color  (fill_color),
        .busy   (fill_busy),
        .done   (fill_done)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter with a registered sram model
module tb_sram_arbiter;

    localparam int DW   = 12;
    localparam int AW   = 17;
    localparam int SIZE = 76800;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [DW-1:0] mem [0:SIZE-1];

    sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_SIZE  (SIZE),
        .MAX_WAIT  (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[int'(bus.mem_addr)] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[int'(bus.mem_addr)];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cyc;
        bit  done_seen;
        int  fill_wr;
        int  b_leak;
        int  a_fill_gnt;

        for (int i = 0; i < SIZE; i++) mem[i] = '0;
        mem[0] = 12'h000;
        mem[1] = 12'h111;
        mem[2] = 12'h222;
        bus.mem_rdata  = '0;
        bus.a_req      = 1'b1;
        bus.a_addr     = '0;
        bus.b_req      = 1'b0;
        bus.b_we       = 1'b0;
        bus.b_addr     = '0;
        bus.b_wdata    = '0;
        bus.fill_start = 1'b0;
        bus.fill_value = '0;
        reset_n        = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("rst_b_rvalid", 32'(bus.b_rvalid), 0);
        chk("rst_fill_busy", 32'(bus.fill_busy), 0);
        chk("rst_fill_done", 32'(bus.fill_done), 0);
        chk("rst_a_rdata", 32'(bus.a_rdata), 0);
        chk("rst_b_rdata", 32'(bus.b_rdata), 0);
        chk("rst_a_gnt", 32'(bus.a_gnt), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        tick();
        reset_n   = 1'b1;
        bus.a_req = 1'b0;

        // port A back-to-back reads of 0, 1, 2
        tick();
        bus.a_req = 1'b1; bus.a_addr = 17'd0;
        @(negedge clk);
        chk("a0_gnt", 32'(bus.a_gnt), 1);
        chk("a0_mem_en", 32'(bus.mem_en), 1);
        chk("a0_mem_we", 32'(bus.mem_we), 0);
        tick();
        bus.a_addr = 17'd1;
        @(negedge clk);
        chk("a1_gnt", 32'(bus.a_gnt), 1);
        chk("a0_rvalid", 32'(bus.a_rvalid), 1);
        chk("a0_rdata", 32'(bus.a_rdata), 32'h000);
        tick();
        bus.a_addr = 17'd2;
        @(negedge clk);
        chk("a2_gnt", 32'(bus.a_gnt), 1);
        chk("a1_rdata", 32'(bus.a_rdata), 32'h111);
        tick();
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("a_idle_gnt", 32'(bus.a_gnt), 0);
        chk("a2_rvalid", 32'(bus.a_rvalid), 1);
        chk("a2_rdata", 32'(bus.a_rdata), 32'h222);
        tick();
        @(negedge clk);
        chk("a_rvalid_low", 32'(bus.a_rvalid), 0);
        chk("a_rdata_hold", 32'(bus.a_rdata), 32'h222);

        // port B write then read of 0x100
        tick();
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 17'h100; bus.b_wdata = 12'hABC;
        @(negedge clk);
        chk("bw_gnt", 32'(bus.b_gnt), 1);
        chk("bw_mem_we", 32'(bus.mem_we), 1);
        chk("bw_mem_addr", 32'(bus.mem_addr), 32'h100);
        chk("bw_mem_wdata", 32'(bus.mem_wdata), 32'hABC);
        tick();
        bus.b_we = 1'b0;
        @(negedge clk);
        chk("br_gnt", 32'(bus.b_gnt), 1);
        chk("bw_no_rvalid", 32'(bus.b_rvalid), 0);
        tick();
        bus.b_req = 1'b0;
        @(negedge clk);
        chk("br_rvalid", 32'(bus.b_rvalid), 1);
        chk("br_rdata", 32'(bus.b_rdata), 32'hABC);

        // starvation: B denied 8 cycles, granted on the 9th
        tick();
        bus.a_req = 1'b1; bus.a_addr = 17'd3;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 17'h100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("starve_b_denied_%0d", i), 32'(bus.b_gnt), 0);
            chk($sformatf("starve_a_gnt_%0d", i), 32'(bus.a_gnt), 1);
            tick();
        end
        @(negedge clk);
        chk("starve_b_gnt", 32'(bus.b_gnt), 1);
        chk("starve_a_held", 32'(bus.a_gnt), 0);
        tick();
        bus.b_req = 1'b0;
        @(negedge clk);
        chk("starve_a_resume", 32'(bus.a_gnt), 1);
        chk("starve_b_rdata", 32'(bus.b_rdata), 32'hABC);
        tick();
        bus.a_req = 1'b0;

        // out of range write and read at 76800
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 17'd76800; bus.b_wdata = 12'h555;
        @(negedge clk);
        chk("oor_w_gnt", 32'(bus.b_gnt), 1);
        chk("oor_w_mem_en", 32'(bus.mem_en), 0);
        tick();
        bus.b_we = 1'b0;
        @(negedge clk);
        chk("oor_r_gnt", 32'(bus.b_gnt), 1);
        chk("oor_r_mem_en", 32'(bus.mem_en), 0);
        tick();
        bus.b_req = 1'b0;
        @(negedge clk);
        chk("oor_r_rvalid", 32'(bus.b_rvalid), 1);
        chk("oor_r_rdata", 32'(bus.b_rdata), 0);

        // full fill with 0xF00, A every other cycle early on, B waiting throughout
        tick();
        bus.fill_start = 1'b1; bus.fill_value = 12'hF00;
        @(negedge clk);
        chk("fill_start_busy", 32'(bus.fill_busy), 0);
        tick();
        bus.fill_start = 1'b0; bus.fill_value = 12'h000;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 17'h100;
        cyc = 0; done_seen = 0; fill_wr = 0; b_leak = 0; a_fill_gnt = 0;
        while (!done_seen && cyc < 100000) begin
            bus.a_req  = (cyc < 40) && (cyc % 2 == 0);
            bus.a_addr = 17'(cyc);
            @(negedge clk);
            if (cyc == 0) chk("fill_busy_high", 32'(bus.fill_busy), 1);
            if (bus.fill_busy && bus.b_gnt) b_leak++;
            if (bus.fill_busy && bus.a_gnt) a_fill_gnt++;
            if (bus.fill_busy && bus.mem_en && bus.mem_we) fill_wr++;
            if (bus.fill_done) begin
                done_seen = 1;
                chk("fill_done_busy_low", 32'(bus.fill_busy), 0);
                chk("fill_done_b_gnt", 32'(bus.b_gnt), 1);
            end
            tick();
            cyc++;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        chk("fill_done_seen", 32'(done_seen), 1);
        chk("fill_writes", 32'(fill_wr), 32'd76800);
        chk("fill_b_leak", 32'(b_leak), 0);
        chk("fill_a_gnts", 32'(a_fill_gnt), 32'd20);
        @(negedge clk);
        chk("fill_done_single", 32'(bus.fill_done), 0);
        chk("fill_b_rdata", 32'(bus.b_rdata), 32'hF00);
        tick();
        bus.a_req = 1'b1; bus.a_addr = 17'h12BFF;
        @(negedge clk);
        chk("post_fill_a_gnt", 32'(bus.a_gnt), 1);
        tick();
        bus.a_addr = 17'd0;
        @(negedge clk);
        chk("post_fill_last", 32'(bus.a_rdata), 32'hF00);
        tick();
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("post_fill_first", 32'(bus.a_rdata), 32'hF00);

        // reset asserted mid-fill
        tick();
        bus.fill_start = 1'b1; bus.fill_value = 12'h0AA;
        tick();
        bus.fill_start = 1'b0;
        repeat (1000) tick();
        bus.a_req = 1'b1; bus.a_addr = 17'h12BFF;
        tick();
        chk("midfill_busy", 32'(bus.fill_busy), 1);
        chk("midfill_a_rvalid", 32'(bus.a_rvalid), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("arst_a_rdata", 32'(bus.a_rdata), 0);
        chk("arst_a_gnt", 32'(bus.a_gnt), 0);
        chk("arst_mem_en", 32'(bus.mem_en), 0);
        chk("arst_fill_busy", 32'(bus.fill_busy), 0);
        chk("arst_fill_done", 32'(bus.fill_done), 0);
        bus.a_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_no_done_%0d", i), 32'(bus.fill_done), 0);
            chk($sformatf("post_rst_idle_%0d", i), 32'(bus.fill_busy), 0);
            tick();
        end
        bus.a_req = 1'b1; bus.a_addr = 17'd5;
        @(negedge clk);
        chk("post_rst_a_gnt", 32'(bus.a_gnt), 1);
        tick();
        bus.a_addr = 17'h12BFF;
        @(negedge clk);
        chk("partial_fill_data", 32'(bus.a_rdata), 32'h0AA);
        tick();
        bus.a_req = 1'b0;
        @(negedge clk);
        chk("aborted_fill_untouched", 32'(bus.a_rdata), 32'hF00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
